usb_ctrl_out_ep_buf: RTL and testbench

Receive-side buffer for control endpoint 0, sitting between the USB full-speed protocol engine and the control-endpoint request handler. Captures SETUP/OUT data packets addressed to endpoint 0 into a local packet buffer and tracks the DATA0/DATA1 toggle. Issues the ACK/NAK/STALL handshake. Replays accepted payload bytes to the handler over the out_ep req/grant/get interface, with one-cycle read latency.

---
 rtl/usb_ctrl_out_ep_buf_if.sv | 22 ++
 rtl/usb_ctrl_out_ep_buf.sv | 210 +++++++++++++++++++++
 tb/tb_usb_ctrl_out_ep_buf.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/usb_ctrl_out_ep_buf_if.sv
// Handler-side port bundle of the endpoint 0 OUT buffer.
// The request handler is the master; the buffer is the slave.
interface usb_ctrl_out_ep_buf_if;
    logic       out_ep_req;
    logic       out_ep_grant;
    logic       out_ep_data_avail;
    logic       out_ep_setup;
    logic       out_ep_data_get;
    logic [7:0] out_ep_data;
    logic       out_ep_stall;
    logic       out_ep_acked;

    modport master (
        output out_ep_req, out_ep_data_get, out_ep_stall,
        input  out_ep_grant, out_ep_data_avail, out_ep_setup, out_ep_data, out_ep_acked
    );

    modport slave (
        input  out_ep_req, out_ep_data_get, out_ep_stall,
        output out_ep_grant, out_ep_data_avail, out_ep_setup, out_ep_data, out_ep_acked
    );
endinterface

// File: rtl/usb_ctrl_out_ep_buf.sv
// Control endpoint 0 receive buffer: captures SETUP/OUT payloads, tracks the
// DATA0/DATA1 toggle, answers with ACK/NAK/STALL and replays accepted bytes
// to the request handler with one-cycle read latency.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | buffer empty, waiting for an OUT/SETUP token to endpoint 0
// TOKEN     | token accepted, waiting for the DATA0/DATA1 packet
// DATA      | capturing payload bytes; handshake decided on packet end
// HANDSHAKE | handshake being driven for one cycle
// READY     | accepted payload held for the handler; OUT tokens are NAKed
module usb_ctrl_out_ep_buf #(
    parameter int MAX_PKT = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_addr_match,
    input  logic                  rx_pkt_start,
    input  logic [3:0]            rx_pid,
    input  logic                  rx_data_put,
    input  logic [7:0]            rx_data,
    input  logic                  rx_pkt_end,
    input  logic                  rx_pkt_valid,
    output logic                  tx_pkt_start,
    output logic [3:0]            tx_pid,
    usb_ctrl_out_ep_buf_if.slave  ep
);
    localparam int PW = $clog2(MAX_PKT) + 1;
    localparam logic [PW-1:0] FULL = PW'(MAX_PKT);

    localparam logic [3:0] PID_OUT   = 4'd1;
    localparam logic [3:0] PID_DATA0 = 4'd3;
    localparam logic [3:0] PID_DATA1 = 4'd11;
    localparam logic [3:0] PID_SETUP = 4'd13;
    localparam logic [3:0] PID_ACK   = 4'd2;
    localparam logic [3:0] PID_NAK   = 4'd10;
    localparam logic [3:0] PID_STALL = 4'd14;

    typedef enum logic [2:0] {
        S_IDLE, S_TOKEN, S_DATA, S_HANDSHAKE, S_READY
    } state_t;

    state_t        state;
    state_t        hs_next;
    logic          is_setup;
    logic          exp_toggle;
    logic          rx_toggle;
    logic          overflow;
    logic          nak;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [7:0]    pkt_mem [MAX_PKT];

    logic          grant_q;
    logic          avail_q;
    logic          setup_q;
    logic [7:0]    data_q;
    logic          acked_q;

    logic          setup_tok;
    logic          out_tok;
    logic          get_ok;
    logic [PW-1:0] rd_inc;
    logic          drained;
    logic          nak_pending;

    assign setup_tok   = rx_pkt_start && rx_addr_match && (rx_pid == PID_SETUP);
    assign out_tok     = rx_pkt_start && rx_addr_match && (rx_pid == PID_OUT);
    assign get_ok      = ep.out_ep_data_get && grant_q && avail_q;
    assign rd_inc      = rd_ptr + PW'(1);
    assign drained     = get_ok && (rd_inc == wr_ptr);
    // A NAK owed to an incoming packet keeps the buffer in READY until it is sent.
    assign nak_pending = (nak && !rx_pkt_end) || out_tok;

    assign ep.out_ep_grant      = grant_q;
    assign ep.out_ep_data_avail = avail_q;
    assign ep.out_ep_setup      = setup_q;
    assign ep.out_ep_data       = data_q;
    assign ep.out_ep_acked      = acked_q;

    // Payload capture; bytes past the buffer end are dropped.
    always_ff @(posedge clk) begin
        if (state == S_DATA && rx_data_put && wr_ptr != FULL)
            pkt_mem[wr_ptr[PW-2:0]] <= rx_data;
    end

    // Endpoint sequencing FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            hs_next      <= S_IDLE;
            is_setup     <= 1'b0;
            exp_toggle   <= 1'b0;
            rx_toggle    <= 1'b0;
            overflow     <= 1'b0;
            nak          <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            tx_pkt_start <= 1'b0;
            tx_pid       <= 4'd0;
            grant_q      <= 1'b0;
            avail_q      <= 1'b0;
            setup_q      <= 1'b0;
            data_q       <= 8'd0;
            acked_q      <= 1'b0;
        end else begin
            tx_pkt_start <= 1'b0;
            acked_q      <= 1'b0;
            case (state)
                S_IDLE: begin
                    grant_q <= 1'b0;
                    if (setup_tok || out_tok) begin
                        state    <= S_TOKEN;
                        is_setup <= setup_tok;
                        setup_q  <= setup_tok;
                        if (setup_tok)
                            exp_toggle <= 1'b0;
                    end
                end
                S_TOKEN: begin
                    if (rx_pkt_start) begin
                        if (rx_pid == PID_DATA0 || rx_pid == PID_DATA1) begin
                            state     <= S_DATA;
                            rx_toggle <= (rx_pid == PID_DATA1);
                            overflow  <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (rx_data_put) begin
                        if (wr_ptr == FULL)
                            overflow <= 1'b1;
                        else
                            wr_ptr <= wr_ptr + PW'(1);
                    end
                    if (rx_pkt_end) begin
                        state   <= S_HANDSHAKE;
                        hs_next <= S_IDLE;
                        if (!rx_pkt_valid || overflow) begin
                            wr_ptr <= '0;
                            rd_ptr <= '0;
                        end else if (!is_setup && ep.out_ep_stall) begin
                            tx_pkt_start <= 1'b1;
                            tx_pid       <= PID_STALL;
                            wr_ptr       <= '0;
                            rd_ptr       <= '0;
                        end else if (rx_toggle != exp_toggle) begin
                            // Retransmission of a packet already accepted.
                            tx_pkt_start <= 1'b1;
                            tx_pid       <= PID_ACK;
                            wr_ptr       <= '0;
                            rd_ptr       <= '0;
                        end else begin
                            tx_pkt_start <= 1'b1;
                            tx_pid       <= PID_ACK;
                            acked_q      <= 1'b1;
                            exp_toggle   <= ~exp_toggle;
                            if (wr_ptr != '0 || rx_data_put)
                                hs_next <= S_READY;
                        end
                    end
                end
                S_HANDSHAKE: begin
                    state <= hs_next;
                    if (hs_next == S_READY)
                        avail_q <= 1'b1;
                end
                S_READY: begin
                    grant_q <= ep.out_ep_req;
                    if (setup_tok) begin
                        state      <= S_TOKEN;
                        is_setup   <= 1'b1;
                        setup_q    <= 1'b1;
                        exp_toggle <= 1'b0;
                        nak        <= 1'b0;
                        wr_ptr     <= '0;
                        rd_ptr     <= '0;
                        avail_q    <= 1'b0;
                        grant_q    <= 1'b0;
                    end else begin
                        if (out_tok)
                            nak <= 1'b1;
                        if (nak && rx_pkt_end) begin
                            nak <= 1'b0;
                            if (rx_pkt_valid) begin
                                tx_pkt_start <= 1'b1;
                                tx_pid       <= PID_NAK;
                            end
                        end
                        if (get_ok) begin
                            data_q <= pkt_mem[rd_ptr[PW-2:0]];
                            rd_ptr <= rd_inc;
                        end
                        if (drained)
                            avail_q <= 1'b0;
                        if ((drained || !avail_q) && !nak_pending) begin
                            state   <= S_IDLE;
                            wr_ptr  <= '0;
                            rd_ptr  <= '0;
                            grant_q <= 1'b0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_ctrl_out_ep_buf.sv
module tb_usb_ctrl_out_ep_buf;
    localparam logic [3:0] OUT = 4'd1, D0 = 4'd3, D1 = 4'd11, SETUP = 4'd13;
    localparam int ACK = 2, NAK = 10, STALL = 14, NONE = -1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_addr_match = 1'b0;
    logic       rx_pkt_start = 1'b0;
    logic [3:0] rx_pid = 4'd0;
    logic       rx_data_put = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       rx_pkt_end = 1'b0;
    logic       rx_pkt_valid = 1'b0;
    logic       tx_pkt_start;
    logic [3:0] tx_pid;

    usb_ctrl_out_ep_buf_if ep_if();

    usb_ctrl_out_ep_buf #(.MAX_PKT(32)) dut (
        .clk(clk), .reset(reset),
        .rx_addr_match(rx_addr_match), .rx_pkt_start(rx_pkt_start), .rx_pid(rx_pid),
        .rx_data_put(rx_data_put), .rx_data(rx_data), .rx_pkt_end(rx_pkt_end),
        .rx_pkt_valid(rx_pkt_valid), .tx_pkt_start(tx_pkt_start), .tx_pid(tx_pid),
        .ep(ep_if)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] pkt [64];
    logic [7:0] exp_q [$];
    int         hs_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tok(input logic [3:0] pid);
        rx_pkt_start  = 1'b1;
        rx_pid        = pid;
        rx_addr_match = 1'b1;
        tick();
        rx_pkt_start  = 1'b0;
        tick();
        tick();
    endtask

    // Sends a data packet; expected handshake goes to hs_q, accepted bytes to exp_q.
    task automatic data_pkt(input logic [3:0] pid, input int n, input logic valid,
                            input int exp_hs, input int exp_ack, input logic push,
                            input int exp_avail);
        int hs;
        hs_q.push_back(exp_hs);
        rx_pkt_start = 1'b1;
        rx_pid       = pid;
        tick();
        rx_pkt_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            rx_data_put = 1'b1;
            rx_data     = pkt[i];
            if (push) exp_q.push_back(pkt[i]);
            tick();
        end
        rx_data_put  = 1'b0;
        rx_pkt_end   = 1'b1;
        rx_pkt_valid = valid;
        tick();
        rx_pkt_end   = 1'b0;
        rx_pkt_valid = 1'b0;
        hs = hs_q.pop_front();
        chk("tx_pkt_start", int'(tx_pkt_start), (hs == NONE) ? 0 : 1);
        if (hs != NONE) chk("tx_pid", int'(tx_pid), hs);
        chk("acked", int'(ep_if.out_ep_acked), exp_ack);
        tick();
        chk("tx_pkt_start_pulse", int'(tx_pkt_start), 0);
        chk("acked_pulse", int'(ep_if.out_ep_acked), 0);
        chk("avail_after_hs", int'(ep_if.out_ep_data_avail), exp_avail);
        tick();
        tick();
    endtask

    task automatic read_n(input int n, input logic expect_end);
        ep_if.out_ep_req = 1'b1;
        tick();
        chk("grant", int'(ep_if.out_ep_grant), 1);
        ep_if.out_ep_data_get = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL scoreboard_empty observed=%0d expected=nothing", ep_if.out_ep_data);
            end else begin
                chk("out_ep_data", int'(ep_if.out_ep_data), int'(exp_q.pop_front()));
            end
            chk("avail_during_read", int'(ep_if.out_ep_data_avail),
                (expect_end && i == n - 1) ? 0 : 1);
        end
        ep_if.out_ep_data_get = 1'b0;
        ep_if.out_ep_req      = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        logic [7:0] setup_bytes [8];
        setup_bytes = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h12, 8'h00};
        ep_if.out_ep_req      = 1'b0;
        ep_if.out_ep_data_get = 1'b0;
        ep_if.out_ep_stall    = 1'b0;

        // Reset values
        tick(); tick(); tick();
        chk("rst_tx_pkt_start", int'(tx_pkt_start), 0);
        chk("rst_tx_pid", int'(tx_pid), 0);
        chk("rst_grant", int'(ep_if.out_ep_grant), 0);
        chk("rst_avail", int'(ep_if.out_ep_data_avail), 0);
        chk("rst_setup", int'(ep_if.out_ep_setup), 0);
        chk("rst_data", int'(ep_if.out_ep_data), 0);
        chk("rst_acked", int'(ep_if.out_ep_acked), 0);
        reset = 1'b0;
        tick();

        // SETUP + DATA0 with a GET_DESCRIPTOR request
        for (int i = 0; i < 8; i++) pkt[i] = setup_bytes[i];
        tok(SETUP);
        chk("setup_flag", int'(ep_if.out_ep_setup), 1);
        data_pkt(D0, 8, 1'b1, ACK, 1, 1'b1, 1);
        read_n(8, 1'b1);

        // OUT + DATA1 zero-length status stage
        tok(OUT);
        chk("setup_flag_out", int'(ep_if.out_ep_setup), 0);
        data_pkt(D1, 0, 1'b1, ACK, 1, 1'b0, 0);

        // OUT + DATA0 accepted, then repeated DATA0 is a retransmission
        for (int i = 0; i < 64; i++) pkt[i] = 8'(i * 7 + 3);
        tok(OUT);
        data_pkt(D0, 4, 1'b1, ACK, 1, 1'b1, 1);
        read_n(4, 1'b1);
        tok(OUT);
        data_pkt(D0, 4, 1'b1, ACK, 0, 1'b0, 0);

        // NAK while 3 bytes are unread; originals remain readable
        for (int i = 0; i < 64; i++) pkt[i] = 8'(8'hA0 + i);
        tok(OUT);
        data_pkt(D1, 8, 1'b1, ACK, 1, 1'b1, 1);
        read_n(5, 1'b0);
        for (int i = 0; i < 64; i++) pkt[i] = 8'(8'h55 ^ i);
        tok(OUT);
        data_pkt(D0, 4, 1'b1, NAK, 0, 1'b0, 1);
        read_n(3, 1'b1);

        // STALL on OUT; SETUP still ACKed with stall requested
        ep_if.out_ep_stall = 1'b1;
        tok(OUT);
        data_pkt(D0, 2, 1'b1, STALL, 0, 1'b0, 0);
        for (int i = 0; i < 8; i++) pkt[i] = setup_bytes[i];
        tok(SETUP);
        data_pkt(D0, 8, 1'b1, ACK, 1, 1'b1, 1);
        read_n(8, 1'b1);
        ep_if.out_ep_stall = 1'b0;

        // Overflow: 33 bytes dropped, no handshake, toggle unchanged
        for (int i = 0; i < 64; i++) pkt[i] = 8'(i);
        tok(OUT);
        data_pkt(D1, 33, 1'b1, NONE, 0, 1'b0, 0);
        tok(OUT);
        data_pkt(D1, 2, 1'b1, ACK, 1, 1'b1, 1);
        read_n(2, 1'b1);

        // Bad CRC: no handshake
        tok(OUT);
        data_pkt(D0, 3, 1'b0, NONE, 0, 1'b0, 0);

        // Reset mid-packet: no handshake, toggle back to DATA0
        tok(OUT);
        data_pkt(D0, 2, 1'b1, ACK, 1, 1'b1, 1);
        read_n(2, 1'b1);
        tok(OUT);
        rx_pkt_start = 1'b1;
        rx_pid       = D1;
        tick();
        rx_pkt_start = 1'b0;
        rx_data_put  = 1'b1;
        rx_data      = 8'h11;
        tick();
        rx_data_put  = 1'b0;
        reset        = 1'b1;
        tick();
        reset        = 1'b0;
        rx_pkt_end   = 1'b1;
        rx_pkt_valid = 1'b1;
        tick();
        rx_pkt_end   = 1'b0;
        rx_pkt_valid = 1'b0;
        chk("rst_mid_tx", int'(tx_pkt_start), 0);
        chk("rst_mid_acked", int'(ep_if.out_ep_acked), 0);
        chk("rst_mid_avail", int'(ep_if.out_ep_data_avail), 0);
        tick();
        tok(OUT);
        data_pkt(D1, 2, 1'b1, ACK, 0, 1'b0, 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
